// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default widths, EX->MEM payload layout and the
// NOP/zero pieces the inter-stage bubble is built from.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W  = 160;
  localparam int unsigned DEF_CARRY_W = 66;

  localparam int unsigned EXM_PC_LSB    = 0;
  localparam int unsigned EXM_ALU_LSB   = 32;
  localparam int unsigned EXM_STORE_LSB = 64;
  localparam int unsigned EXM_INSTR_LSB = 96;
  localparam int unsigned EXM_CTRL_LSB  = 128;
  localparam int unsigned EXM_FIELD_W   = 32;

  localparam logic [EXM_FIELD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [EXM_FIELD_W-1:0] WORD_ZERO = '0;
  localparam logic [EXM_FIELD_W-1:0] CTRL_ZERO = '0;

  localparam logic [DEF_DATA_W-1:0] EXM_BUBBLE =
    {CTRL_ZERO, NOP_INSTR, WORD_ZERO, WORD_ZERO, WORD_ZERO};

  typedef enum logic [2:0] {
    BUF_IDLE,
    BUF_PUSH,
    BUF_POP,
    BUF_SWAP,
    BUF_FLUSH
  } buf_op_e;

  function automatic buf_op_e decode_op(input logic flush, input logic push,
                                        input logic pop);
    if (flush)            return BUF_FLUSH;
    else if (push && pop) return BUF_SWAP;
    else if (push)        return BUF_PUSH;
    else if (pop)         return BUF_POP;
    else                  return BUF_IDLE;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One buffer entry: payload register plus valid bit; clear beats load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry in-order skid buffer between pipeline stages, with a multi-cycle
// carry returned upstream one cycle later.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W  = DEF_DATA_W,
  parameter int unsigned        CARRY_W = DEF_CARRY_W,
  parameter logic [DATA_W-1:0]  BUBBLE  = DATA_W'(EXM_BUBBLE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_hold,
  input  logic [CARRY_W-1:0] carry_i,
  output logic [CARRY_W-1:0] carry_o,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         count
);

  logic              head_v, skid_v;
  logic [DATA_W-1:0] head_q, skid_q;
  logic              head_load, head_clr, skid_load, skid_clr;
  logic [DATA_W-1:0] head_d;
  logic              push, pop;
  buf_op_e           op;

  // The skid entry is only ever occupied behind a valid head.
  assign count     = skid_v ? 2'd2 : (head_v ? 2'd1 : 2'd0);
  assign in_ready  = (count != 2'd2);
  assign out_valid = head_v;
  assign out_data  = head_v ? head_q : BUBBLE;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign op   = decode_op(flush, push, pop);

  always_comb begin
    head_load = 1'b0;
    head_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    head_d    = in_data;
    unique case (op)
      BUF_FLUSH: begin
        head_clr = 1'b1;
        skid_clr = 1'b1;
      end
      // Push needs a free slot, so swap only happens with the skid empty.
      BUF_SWAP: head_load = 1'b1;
      BUF_PUSH: begin
        if (head_v) skid_load = 1'b1;
        else        head_load = 1'b1;
      end
      BUF_POP: begin
        if (skid_v) begin
          head_load = 1'b1;
          head_d    = skid_q;
          skid_clr  = 1'b1;
        end else begin
          head_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pipe_slot #(.DATA_W(DATA_W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .load  (head_load),
    .clear (head_clr),
    .d     (head_d),
    .valid (head_v),
    .q     (head_q)
  );

  pipe_slot #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_data),
    .valid (skid_v),
    .q     (skid_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          carry_o <= '0;
    else if (flush)   carry_o <= '0;
    else if (in_hold) carry_o <= carry_i;
    else if (push)    carry_o <= '0;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: occupancy/carry model checked every cycle,
// delivered payloads checked in order against a scoreboard queue.
module tb_pipe_stage_buf;
  localparam int unsigned DW = 160;
  localparam int unsigned CW = 66;
  localparam logic [DW-1:0] BUB = {40'hB0B0_B0B0_B0, 120'h0, 8'h5A} >> 8;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_hold, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] carry_i, carry_o;
  logic [1:0]    count;

  int unsigned   tests = 0;
  int unsigned   fails = 0;
  int unsigned   delivered = 0;
  logic [DW-1:0] sb[$];
  int unsigned   mcount;
  logic [CW-1:0] mcarry;

  pipe_stage_buf #(.DATA_W(DW), .CARRY_W(CW), .BUBBLE(BUB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_hold(in_hold), .carry_i(carry_i), .carry_o(carry_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 200'(out_data), 200'(BUB));
      end else begin
        chk("out_data", 200'(out_data), 200'(sb.pop_front()));
        delivered++;
      end
    end
  end

  // One clock cycle with the currently driven inputs; checks model state first.
  task automatic step();
    logic r0, push, pop;
    r0 = in_ready;
    out_ready = ~out_ready;
    #1;
    chk("in_ready_vs_out_ready", 200'(in_ready), 200'(r0));
    out_ready = ~out_ready;
    #1;
    @(negedge clk);
    chk("count", 200'(count), 200'(mcount));
    chk("in_ready", 200'(in_ready), 200'(mcount != 2));
    chk("out_valid", 200'(out_valid), 200'(mcount != 0));
    if (mcount == 0) chk("bubble", 200'(out_data), 200'(BUB));
    chk("carry_o", 200'(carry_o), 200'(mcarry));
    push = in_valid && (mcount != 2);
    pop  = (mcount != 0) && out_ready;
    if (flush) begin
      mcount = 0;
      mcarry = '0;
      sb.delete();
    end else begin
      if (push) sb.push_back(in_data);
      mcount = mcount + (push ? 1 : 0) - (pop ? 1 : 0);
      if (in_hold)   mcarry = carry_i;
      else if (push) mcarry = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_hold  = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nxt, cyc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_hold = 1'b0;
    in_data = '0; carry_i = '0; out_ready = 1'b0;
    mcount = 0; mcarry = '0;
    #2;
    chk("rst_count", 200'(count), 200'(0));
    chk("rst_out_valid", 200'(out_valid), 200'(0));
    chk("rst_out_data", 200'(out_data), 200'(BUB));
    chk("rst_carry", 200'(carry_o), 200'(0));
    chk("rst_in_ready", 200'(in_ready), 200'(1));
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single entry through an empty buffer
    in_valid = 1'b1; in_data = DW'('hA5); out_ready = 1'b1;
    step();
    idle_in();
    chk("lat1_data", 200'(out_data), 200'('hA5));
    step();
    step();

    // Fill to two, third offer refused, then drain in order
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      step();
    end
    chk("full_count", 200'(count), 200'(2));
    chk("full_in_ready", 200'(in_ready), 200'(0));
    idle_in(); out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Full buffer: hold while full, then flush beats push and hold
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DW'('h10); step();
    in_data = DW'('h11); step();
    in_valid = 1'b0; in_hold = 1'b1; carry_i = CW'('h55); step();
    flush = 1'b1; in_valid = 1'b1; in_data = DW'('h99); carry_i = CW'('h66); step();
    idle_in(); out_ready = 1'b1;
    chk("flush_data", 200'(out_data), 200'(BUB));
    chk("flush_carry", 200'(carry_o), 200'(0));
    for (int i = 0; i < 3; i++) step();

    // Hold on an empty buffer: carry follows, count unchanged, push clears it
    in_hold = 1'b1;
    carry_i = 66'h1_0000_0000_0000_0002; step();
    carry_i = 66'h1_0000_0000_0000_0003; step();
    carry_i = 66'h1_0000_0000_0000_0004; step();
    in_hold = 1'b0; in_valid = 1'b1; in_data = DW'('h20); step();
    in_valid = 1'b1; in_hold = 1'b1; in_data = DW'('h21); carry_i = CW'('h3FF); step();
    idle_in(); step(); step();

    // Stream 0..99 against a randomly stalling consumer
    nxt = 0; cyc = 0; delivered = 0;
    while ((nxt < 100 || mcount != 0) && cyc < 1000) begin
      in_valid = (nxt < 100);
      in_data = DW'(nxt) | (DW'(nxt) << 140);
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && mcount != 2) nxt++;
      step();
      cyc++;
    end
    idle_in();
    chk("stream_done", 200'(cyc < 1000), 200'(1));
    chk("stream_delivered", 200'(delivered), 200'(100));
    chk("stream_sb_empty", 200'(sb.size()), 200'(0));

    // Asynchronous reset while full
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DW'('h30); step();
    in_data = DW'('h31); in_hold = 1'b1; carry_i = CW'('h3C); step();
    idle_in();
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 200'(count), 200'(0));
    chk("arst_out_valid", 200'(out_valid), 200'(0));
    chk("arst_out_data", 200'(out_data), 200'(BUB));
    chk("arst_carry", 200'(carry_o), 200'(0));
    chk("arst_in_ready", 200'(in_ready), 200'(1));
    sb.delete(); mcount = 0; mcarry = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = DW'('h77); out_ready = 1'b1; step();
    idle_in(); step(); step();
    chk("final_sb_empty", 200'(sb.size()), 200'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
